fpnew_output_arbiter: RTL and testbench
=======================================

// Module: fpnew_output_arbiter
// PURPOSE
//   Merges the result streams of NumInputs operation-group output pipelines into one FPU result port.
//   Sits directly downstream of the per-opgroup output pipeline stages.
//   Each source presents a valid/ready handshake; a round-robin arbiter picks one source per cycle.
//   The winner lands in a 2-entry output buffer, so in_ready_o never combinationally depends on out_ready_i.
// PARAMETERS
//   NumInputs  4   number of upstream result sources (>=2)
//   Width      32  result width in bits
//   TagWidth   1   width of tag sideband
//   AuxWidth   1   width of aux sideband
// PORTS
//   clk_i               in   1                  clock, all state on rising edge
//   rst_i               in   1                  reset, synchronous, active-high
//   flush_i             in   1                  synchronous clear of all buffered results
//   in_result_i         in   NumInputs*Width    per-source result
//   in_status_i         in   NumInputs*5        per-source status flags {NV,DZ,OF,UF,NX}
//   in_extension_bit_i  in   NumInputs          per-source extension bit
//   in_tag_i            in   NumInputs*TagWidth per-source tag
//   in_aux_i            in   NumInputs*AuxWidth per-source aux
//   in_valid_i          in   NumInputs          per-source valid
//   in_ready_o          out  NumInputs          per-source ready (one-hot or zero)
//   result_o            out  Width              head-entry result
//   status_o            out  5                  head-entry status
//   extension_bit_o     out  1                  head-entry extension bit
//   tag_o               out  TagWidth           head-entry tag
//   aux_o               out  AuxWidth           head-entry aux
//   out_valid_o         out  1                  head entry valid
//   out_ready_i         in   1                  downstream accepts head
//   busy_o              out  1                  any valid input or buffered result
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge): count=0, rr_ptr=0, both entries' data=0.
//     Outputs: out_valid_o=0, result_o/status_o/extension_bit_o/tag_o/aux_o=0, in_ready_o=0 during reset.
//   Buffer: 2-entry FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
//     Outputs are driven from entry[rd_ptr]. out_valid_o = (count!=0).
//   Arbitration: space = (count<2) & ~flush_i & ~rst_i; space uses registered count only.
//     grant = first index g, searching rr_ptr, rr_ptr+1, ... mod NumInputs, with in_valid_i[g]=1.
//     in_ready_o[g] = space & (g==grant); all other bits 0; all bits 0 if no valid input.
//   push = |(in_valid_i & in_ready_o)  -> entry[wr_ptr] <= granted source's fields; wr_ptr toggles.
//   On push: rr_ptr <= (grant+1) mod NumInputs. No push: rr_ptr holds.
//   pop = out_valid_o & out_ready_i -> rd_ptr toggles.
//   count: push&~pop +1; pop&~push -1; push&pop or neither: unchanged.
//   Latency: accepted input appears on outputs the next cycle (1 cycle) when the buffer was empty.
//   Throughput: 1 result/cycle sustained while out_ready_i=1.
//   Full (count=2): in_ready_o=0 even if out_ready_i=1 that cycle.
//     The pop frees a slot, seen on the next cycle.
//   Outputs hold stable while out_valid_o=1 & out_ready_i=0.
//   Sources are never starved: a valid source waits at most NumInputs-1 grants.
//   flush_i=1: count<=0, rd_ptr<=0, wr_ptr<=0 next edge; no push that cycle; rr_ptr held.
//     Data registers are not cleared.
//   rst_i has priority over flush_i; reset mid-stream discards buffered entries.
//   busy_o = (|in_valid_i) | out_valid_o (combinational).
// TESTING
//   1) Reset; in_valid_i=4'b0001, result=32'h3F80_0000, out_ready_i=1
//      -> next cycle out_valid_o=1, result_o=32'h3F80_0000; in_ready_o=4'b0001.
//   2) in_valid_i=4'b1111 held, out_ready_i=1, distinct results per source
//      -> grant order 0,1,2,3,0,... one result/cycle.
//   3) out_ready_i=0, in_valid_i=4'b0011 -> 2 pushes (src0, src1), then in_ready_o=0, count=2.
//      Raise out_ready_i -> src0 result, then src1 result, in order.
//   4) Full buffer and out_ready_i=1 in the same cycle -> in_ready_o=0 that cycle, push allowed next cycle.
//   5) count=2, assert flush_i one cycle -> out_valid_o=0 next cycle; busy_o=0 if in_valid_i=0.
//   6) Assert rst_i while count=1 and in_valid_i=4'b0100 -> no push; after reset out_valid_o=0, rr_ptr=0.

Source files
------------

// File: rtl/fpnew_output_arbiter.sv
// Round-robin merge of per-opgroup result streams into a single FPU result port.
// A 2-entry output buffer decouples in_ready_o from out_ready_i.
module fpnew_output_arbiter #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned Width     = 32,
    parameter int unsigned TagWidth  = 1,
    parameter int unsigned AuxWidth  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NumInputs*Width-1:0]    in_result_i,
    input  logic [NumInputs*5-1:0]        in_status_i,
    input  logic [NumInputs-1:0]          in_extension_bit_i,
    input  logic [NumInputs*TagWidth-1:0] in_tag_i,
    input  logic [NumInputs*AuxWidth-1:0] in_aux_i,
    input  logic [NumInputs-1:0]          in_valid_i,
    output logic [NumInputs-1:0]          in_ready_o,
    output logic [Width-1:0]              result_o,
    output logic [4:0]                    status_o,
    output logic                          extension_bit_o,
    output logic [TagWidth-1:0]           tag_o,
    output logic [AuxWidth-1:0]           aux_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
);

    localparam int unsigned PtrW   = (NumInputs > 1) ? $clog2(NumInputs) : 1;
    localparam int unsigned EntryW = Width + 5 + 1 + TagWidth + AuxWidth;

    logic [EntryW-1:0] entry_q [2];
    logic [EntryW-1:0] entry_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;

    logic              space;
    logic              found;
    logic [PtrW-1:0]   grant;
    logic              push;
    logic              pop;
    logic [EntryW-1:0] new_entry;
    logic [EntryW-1:0] head;
    int                idx;

    // Head entry drives all result outputs
    assign head            = entry_q[rd_ptr_q];
    assign result_o        = head[EntryW-1 -: Width];
    assign status_o        = head[TagWidth+AuxWidth+1 +: 5];
    assign extension_bit_o = head[TagWidth+AuxWidth];
    assign tag_o           = head[AuxWidth +: TagWidth];
    assign aux_o           = head[AuxWidth-1:0];
    assign out_valid_o     = (count_q != 2'd0);
    assign busy_o          = (|in_valid_i) | out_valid_o;

    // Round-robin grant: walk downwards so the lowest offset from rr_ptr wins
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NumInputs)) idx = idx - int'(NumInputs);
            if (in_valid_i[idx]) begin
                found = 1'b1;
                grant = PtrW'(idx);
            end
        end
    end

    always_comb begin
        space      = (count_q < 2'd2) & ~flush_i & ~rst_i;
        in_ready_o = '0;
        if (space && found) in_ready_o[grant] = 1'b1;
        push       = space & found;
        pop        = out_valid_o & out_ready_i;
        new_entry  = {in_result_i[int'(grant)*Width +: Width],
                      in_status_i[int'(grant)*5 +: 5],
                      in_extension_bit_i[grant],
                      in_tag_i[int'(grant)*TagWidth +: TagWidth],
                      in_aux_i[int'(grant)*AuxWidth +: AuxWidth]};
    end

    // Buffer and pointer next-state
    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = new_entry;
                wr_ptr_d          = ~wr_ptr_q;
                rr_ptr_d          = (int'(grant) == int'(NumInputs) - 1) ? '0 : PtrW'(grant + 1'b1);
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rr_ptr_q   <= '0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fpnew_output_arbiter.sv
// Directed bench for fpnew_output_arbiter: arbitration order, buffering, flush and reset.
module tb_fpnew_output_arbiter;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [127:0] in_result;
    logic [19:0]  in_status;
    logic [3:0]   in_ext;
    logic [3:0]   in_tag;
    logic [3:0]   in_aux;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  result;
    logic [4:0]   status;
    logic         ext;
    logic [0:0]   tag;
    logic [0:0]   aux;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int tests;
    int fails;
    int exp_g [6];

    fpnew_output_arbiter #(
        .NumInputs(4), .Width(32), .TagWidth(1), .AuxWidth(1)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .in_result_i       (in_result),
        .in_status_i       (in_status),
        .in_extension_bit_i(in_ext),
        .in_tag_i          (in_tag),
        .in_aux_i          (in_aux),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .result_o          (result),
        .status_o          (status),
        .extension_bit_o   (ext),
        .tag_o             (tag),
        .aux_o             (aux),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag_s, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [31:0] r, input logic [4:0] s,
                           input logic e, input logic t, input logic a);
        in_result[i*32 +: 32] = r;
        in_status[i*5 +: 5]   = s;
        in_ext[i]             = e;
        in_tag[i]             = t;
        in_aux[i]             = a;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_g = '{1, 2, 3, 0, 1, 2};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_result = '0; in_status = '0; in_ext = '0; in_tag = '0; in_aux = '0;
        in_valid = 4'b0001;

        // Reset state
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_status", 32'(status), 32'h0);

        // 1) single push, one-cycle latency
        rst = 1'b0; out_ready = 1'b1;
        set_src(0, 32'h3F80_0000, 5'h15, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t1_in_ready", 32'(in_ready), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        step();
        in_valid = 4'b0000;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_result", result, 32'h3F80_0000);
        chk("t1_status", 32'(status), 32'h15);
        chk("t1_ext", 32'(ext), 32'h1);
        chk("t1_tag", 32'(tag), 32'h1);
        chk("t1_aux", 32'(aux), 32'h0);
        step();
        chk("t1_drained", 32'(out_valid), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);

        // 2) all sources valid: rr_ptr is 1 after test 1, so order 1,2,3,0,1,2
        for (int i = 0; i < 4; i++)
            set_src(i, 32'h1000_0000 + 32'(i), 5'(i + 1), i[0], i[1], i[0]);
        in_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("t2_in_ready", 32'(in_ready), 32'(1) << exp_g[j]);
            step();
            chk("t2_result", result, 32'h1000_0000 + 32'(exp_g[j]));
            chk("t2_status", 32'(status), 32'(exp_g[j] + 1));
            chk("t2_out_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 4'b0000;
        step();

        // 3) stall: two pushes fill the buffer (rr_ptr=3 -> src0 first)
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        #1;
        chk("t3_grant0", 32'(in_ready), 32'h1);
        step();
        chk("t3_out_valid", 32'(out_valid), 32'h1);
        chk("t3_head0", result, 32'h1000_0000);
        chk("t3_grant1", 32'(in_ready), 32'h2);
        step();
        chk("t3_full_ready", 32'(in_ready), 32'h0);
        chk("t3_hold0", result, 32'h1000_0000);
        step();
        chk("t3_hold1", result, 32'h1000_0000);
        chk("t3_full_ready2", 32'(in_ready), 32'h0);

        // 4) full and out_ready in the same cycle: no push until the next cycle
        out_ready = 1'b1;
        #1;
        chk("t4_full_pop_ready", 32'(in_ready), 32'h0);
        step();
        chk("t4_head1", result, 32'h1000_0001);
        chk("t4_ready_after", 32'(in_ready), 32'h1);
        step();
        chk("t4_head_src0", result, 32'h1000_0000);
        chk("t4_out_valid", 32'(out_valid), 32'h1);

        // 5) fill to two then flush (rr_ptr=1 -> src2)
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        chk("t5_grant2", 32'(in_ready), 32'h4);
        step();
        chk("t5_full_ready", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        flush    = 1'b1;
        #1;
        chk("t5_busy_pre", 32'(busy), 32'h1);
        step();
        flush = 1'b0;
        #1;
        chk("t5_flushed", 32'(out_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);

        // 6) reset with one entry buffered and a pending source; rr_ptr=3 -> src0
        in_valid = 4'b0001;
        #1;
        chk("t6_grant0", 32'(in_ready), 32'h1);
        step();
        chk("t6_count1", 32'(out_valid), 32'h1);
        chk("t6_head", result, 32'h1000_0000);
        in_valid = 4'b0100;
        rst      = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(in_ready), 32'h0);
        step();
        rst      = 1'b0;
        in_valid = 4'b0000;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        chk("t6_result", result, 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("t6_rr_reset", 32'(in_ready), 32'h1);
        step();
        chk("t6_post_result", result, 32'h1000_0000);
        in_valid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
